// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES round scheduler.
//   BLOCK_W       : block and round-key width (fixed at 128).
//   MAX_KEYS      : largest key schedule the key-slice helper can address.
//   sched_state_e : scheduler FSM encoding.
//   key_slice()   : returns 128-bit key idx from a zero-padded key vector.
package aes_sched_pkg;

  localparam int BLOCK_W  = 128;
  localparam int MAX_KEYS = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } sched_state_e;

  // Out-of-range indices land in the zero padding and return all-zero keys.
  function automatic logic [BLOCK_W-1:0] key_slice(
    input logic [BLOCK_W*MAX_KEYS-1:0] keys,
    input int unsigned                 idx
  );
    return keys[idx*BLOCK_W +: BLOCK_W];
  endfunction

endpackage

// File: rtl/aes_round_key_mux.sv
// Combinational round-key selector.
//   round_keys_i : packed key schedule, key i at bits [i*128 +: 128]
//   idx_i        : key index (round counter)
//   key_o        : selected 128-bit key
// NUM_ROUNDS+1 must not exceed MAX_KEYS from the package.
module aes_round_key_mux
  import aes_sched_pkg::*;
#(
  parameter  int NUM_ROUNDS = 4,
  localparam int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic [BLOCK_W*(NUM_ROUNDS+1)-1:0] round_keys_i,
  input  logic [CNT_W-1:0]                  idx_i,
  output logic [BLOCK_W-1:0]                key_o
);

  logic [BLOCK_W*MAX_KEYS-1:0] padded_keys;

  always_comb begin
    padded_keys = '0;
    padded_keys[BLOCK_W*(NUM_ROUNDS+1)-1:0] = round_keys_i;
    key_o = key_slice(padded_keys, 32'(idx_i));
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Sequences one block through an external AES round engine.
//   clk, rst          : clock, synchronous active-high reset
//   round_keys        : key schedule, key i at bits [i*128 +: 128]
//   keys_valid        : key schedule usable; loss during rounds aborts the block
//   in_valid/in_ready/in_data      : block input handshake
//   rnd_req/rnd_ack/rnd_state/rnd_key/rnd_last/rnd_result : round engine port
//   out_valid/out_ready/out_data   : result handshake
//   busy, round_idx, abort, dbg_state : status and debug
//
// Handshakes: a transfer happens on every rising edge where valid and
// ready/ack are both high; the initiator holds valid (or req) and its payload
// stable until that edge. rnd_ack is combinational in the engine, so a request
// accepted in a cycle returns rnd_result in that same cycle.
module aes_round_scheduler
  import aes_sched_pkg::*;
#(
  parameter  int NUM_ROUNDS = 4,
  localparam int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BLOCK_W*(NUM_ROUNDS+1)-1:0] round_keys,
  input  logic                              keys_valid,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BLOCK_W-1:0]                in_data,
  output logic                              rnd_req,
  input  logic                              rnd_ack,
  output logic [BLOCK_W-1:0]                rnd_state,
  output logic [BLOCK_W-1:0]                rnd_key,
  output logic                              rnd_last,
  input  logic [BLOCK_W-1:0]                rnd_result,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BLOCK_W-1:0]                out_data,
  output logic                              busy,
  output logic [CNT_W-1:0]                  round_idx,
  output logic                              abort,
  output logic [1:0]                        dbg_state
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS);

  sched_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic               abort_q, abort_d;
  logic [BLOCK_W-1:0] cur_key;
  logic               is_last;
  logic               accept;

  aes_round_key_mux #(
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_key_mux (
    .round_keys_i(round_keys),
    .idx_i       (cnt_q),
    .key_o       (cur_key)
  );

  assign is_last = (cnt_q == LAST_IDX);
  // Reset also gates in_ready so nothing is accepted on a reset edge.
  assign accept  = (state_q == S_IDLE) && keys_valid && !rst && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    abort_d   = 1'b0;
    in_ready  = 1'b0;
    rnd_req   = 1'b0;
    rnd_state = '0;
    rnd_key   = '0;
    rnd_last  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = keys_valid && !rst;
        if (accept) begin
          // Initial AddRoundKey is done here; the engine only sees rounds 1..N.
          blk_d   = in_data ^ round_keys[BLOCK_W-1:0];
          cnt_d   = CNT_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy      = 1'b1;
        rnd_req   = 1'b1;
        rnd_state = blk_q;
        rnd_key   = cur_key;
        rnd_last  = is_last;
        // Key loss takes priority over a same-cycle ack; that result is dropped.
        if (!keys_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (rnd_ack) begin
          blk_d = rnd_result;
          if (is_last) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = blk_q;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign round_idx = cnt_q;
  assign abort     = abort_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler with an XOR round-engine stub
// (result = state ^ key) and a configurable ack delay.
module tb_aes_round_scheduler;

  localparam int NR = 4;
  localparam int CW = 3;

  localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KF   = {128{1'b1}};
  localparam logic [127:0] K3   = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] S0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] S0N  = 128'he6c21c415f0b1dd4653972d51607b7f7;
  localparam logic [127:0] S0K3 = 128'h181ea6d9295f2fc49be5c84d605385e7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic [128*5-1:0]   round_keys;
  logic               keys_valid = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [127:0]       in_data = '0;
  logic               rnd_req;
  logic               rnd_ack;
  logic [127:0]       rnd_state;
  logic [127:0]       rnd_key;
  logic               rnd_last;
  logic [127:0]       rnd_result;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [127:0]       out_data;
  logic               busy;
  logic [CW-1:0]      round_idx;
  logic               abort;
  logic [1:0]         dbg_state;

  assign round_keys = {K3, K3, KF, KF, K0};

  aes_round_scheduler #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .round_keys(round_keys),
    .keys_valid(keys_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rnd_req   (rnd_req),
    .rnd_ack   (rnd_ack),
    .rnd_state (rnd_state),
    .rnd_key   (rnd_key),
    .rnd_last  (rnd_last),
    .rnd_result(rnd_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_idx (round_idx),
    .abort     (abort),
    .dbg_state (dbg_state)
  );

  // ---------------- round engine stub ----------------
  int ack_delay = 0;
  int wait_cnt  = 0;
  always @(posedge clk) begin
    if (rst || !rnd_req || rnd_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign rnd_ack    = rnd_req && (wait_cnt == ack_delay);
  assign rnd_result = rnd_state ^ rnd_key;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  logic [127:0] cmd_state[$];
  logic [127:0] cmd_key[$];
  logic         cmd_last[$];
  int           cmd_cyc[$];
  int           cmd_idx[$];
  int cyc = 0;
  int abort_n = 0;
  int out_n = 0;
  int ov_cyc = -1;
  int hold_err = 0;
  int acc_cyc = 0;
  logic         prev_pending = 1'b0;
  logic [127:0] prev_state = '0;
  logic [127:0] prev_key = '0;
  logic         prev_last = 1'b0;
  logic         prev_ov = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    cmd_state.delete(); cmd_key.delete(); cmd_last.delete();
    cmd_cyc.delete(); cmd_idx.delete();
    abort_n = 0; out_n = 0; ov_cyc = -1; hold_err = 0;
  endtask

  // Advance to the next falling edge and log what the DUT shows there.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rnd_req && prev_pending &&
        (rnd_state !== prev_state || rnd_key !== prev_key || rnd_last !== prev_last))
      hold_err++;
    prev_pending = rnd_req && !rnd_ack;
    prev_state   = rnd_state;
    prev_key     = rnd_key;
    prev_last    = rnd_last;
    if (rnd_req && rnd_ack) begin
      cmd_state.push_back(rnd_state);
      cmd_key.push_back(rnd_key);
      cmd_last.push_back(rnd_last);
      cmd_cyc.push_back(cyc);
      cmd_idx.push_back(int'(round_idx));
    end
    if (abort) abort_n++;
    if (out_valid && !prev_ov && ov_cyc < 0) ov_cyc = cyc;
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      out_n++;
      if (exp_q.size() > 0) check_eq("out_data", out_data, exp_q.pop_front());
      else check_eq("spurious_out", {127'b0, out_valid}, 128'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Call right after step(): offers a block and returns after the accepting edge.
  task automatic offer(input logic [127:0] d);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin
        acc_cyc = cyc;
        ok = 1;
        break;
      end
      step();
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    if (!ok) check_eq("accept_timeout", {127'b0, in_ready}, 128'd1);
  endtask

  task automatic wait_out(input string tag, input int budget);
    int start = out_n;
    for (int i = 0; i < budget && out_n == start; i++) step();
    check_eq({tag, "_out_timeout"}, 128'(out_n - start), 128'd1);
  endtask

  task automatic wait_round(input string tag, input int idx);
    int i = 0;
    while (!(rnd_req && int'(round_idx) == idx) && i < 40) begin
      step();
      i++;
    end
    check_eq({tag, "_round_seen"}, 128'(round_idx), 128'(idx));
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_in_ready"}, {127'b0, in_ready}, 128'd0);
    check_eq({tag, "_rnd_req"}, {127'b0, rnd_req}, 128'd0);
    check_eq({tag, "_out_valid"}, {127'b0, out_valid}, 128'd0);
    check_eq({tag, "_busy"}, {127'b0, busy}, 128'd0);
    check_eq({tag, "_abort"}, {127'b0, abort}, 128'd0);
    check_eq({tag, "_round_idx"}, 128'(round_idx), 128'd0);
    check_eq({tag, "_rnd_state"}, rnd_state, 128'd0);
    check_eq({tag, "_out_data"}, out_data, 128'd0);
    check_eq({tag, "_dbg_state"}, 128'(dbg_state), 128'd0);
  endtask

  task automatic check_full_block(input string tag);
    check_eq({tag, "_ncmd"}, 128'(cmd_state.size()), 128'd4);
    if (cmd_state.size() == 4) begin
      check_eq({tag, "_st1"}, cmd_state[0], S0);
      check_eq({tag, "_st2"}, cmd_state[1], S0N);
      check_eq({tag, "_st3"}, cmd_state[2], S0);
      check_eq({tag, "_st4"}, cmd_state[3], S0K3);
      check_eq({tag, "_key1"}, cmd_key[0], KF);
      check_eq({tag, "_key2"}, cmd_key[1], KF);
      check_eq({tag, "_key3"}, cmd_key[2], K3);
      check_eq({tag, "_key4"}, cmd_key[3], K3);
      check_eq({tag, "_last"}, {124'b0, cmd_last[0], cmd_last[1], cmd_last[2], cmd_last[3]}, 128'b0001);
      check_eq({tag, "_idx1"}, 128'(cmd_idx[0]), 128'd1);
      check_eq({tag, "_idx4"}, 128'(cmd_idx[3]), 128'd4);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset with keys valid: everything quiet, in_ready held low.
    rst = 1'b1;
    keys_valid = 1'b1;
    step(); step(); step();
    check_quiet("reset");
    rst = 1'b0;
    #1;
    check_eq("post_reset_in_ready", {127'b0, in_ready}, 128'd1);
    step();

    // 1: immediate ack.
    clear_logs();
    ack_delay = 0;
    exp_q.push_back(S0);
    offer(PT);
    wait_out("s1", 30);
    check_full_block("s1");
    if (cmd_cyc.size() == 4) begin
      check_eq("s1_first_cmd_cyc", 128'(cmd_cyc[0] - acc_cyc), 128'd1);
      check_eq("s1_last_cmd_cyc", 128'(cmd_cyc[3] - acc_cyc), 128'd4);
    end
    check_eq("s1_out_latency", 128'(ov_cyc - acc_cyc), 128'd5);
    check_eq("s1_abort_count", 128'(abort_n), 128'd0);
    step();

    // 2: ack delayed by 3 cycles per round.
    clear_logs();
    ack_delay = 3;
    exp_q.push_back(S0);
    offer(PT);
    wait_out("s2", 60);
    check_full_block("s2");
    check_eq("s2_out_latency", 128'(ov_cyc - acc_cyc), 128'd17);
    check_eq("s2_hold_stable", 128'(hold_err), 128'd0);
    step();

    // 3: sink stalls for 6 cycles, then a second block (zero plaintext -> K0).
    clear_logs();
    ack_delay = 0;
    out_ready = 1'b0;
    exp_q.push_back(S0);
    offer(PT);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("s3_hold_valid", {127'b0, out_valid}, 128'd1);
      check_eq("s3_hold_data", out_data, S0);
      check_eq("s3_in_ready_low", {127'b0, in_ready}, 128'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    step();
    check_eq("s3_out_count", 128'(out_n), 128'd1);
    step();
    check_eq("s3_in_ready_after", {127'b0, in_ready}, 128'd1);
    clear_logs();
    exp_q.push_back(K0);
    offer(128'd0);
    wait_out("s3b", 30);
    check_eq("s3b_out_latency", 128'(ov_cyc - acc_cyc), 128'd5);
    step();

    // 4: keys invalid out of reset.
    rst = 1'b1;
    keys_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_eq("s4_in_ready_low", {127'b0, in_ready}, 128'd0);
    in_valid = 1'b1;
    in_data = PT;
    step(); step(); step();
    check_eq("s4_ignored_busy", {127'b0, busy}, 128'd0);
    check_eq("s4_ignored_state", 128'(dbg_state), 128'd0);
    in_valid = 1'b0;
    keys_valid = 1'b1;
    #1;
    check_eq("s4_in_ready_same_cycle", {127'b0, in_ready}, 128'd1);
    step();

    // 5: key loss during round 2.
    clear_logs();
    ack_delay = 2;
    offer(PT);
    wait_round("s5", 2);
    keys_valid = 1'b0;
    step();
    check_eq("s5_req_low", {127'b0, rnd_req}, 128'd0);
    check_eq("s5_abort_pulse", {127'b0, abort}, 128'd1);
    check_eq("s5_idle", 128'(dbg_state), 128'd0);
    step();
    check_eq("s5_abort_one_cycle", {127'b0, abort}, 128'd0);
    keys_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_eq("s5_no_output", 128'(out_n), 128'd0);
    check_eq("s5_no_out_valid", 128'(ov_cyc), 128'(-1));
    check_eq("s5_abort_count", 128'(abort_n), 128'd1);

    // 6: reset in the middle of round 3, then a fresh block.
    clear_logs();
    ack_delay = 1;
    offer(PT);
    wait_round("s6", 3);
    rst = 1'b1;
    step();
    check_quiet("s6_rst");
    rst = 1'b0;
    step();
    check_eq("s6_no_abort", 128'(abort_n), 128'd0);
    clear_logs();
    ack_delay = 0;
    exp_q.push_back(S0);
    offer(PT);
    wait_out("s6b", 30);
    check_full_block("s6b");
    check_eq("s6b_out_latency", 128'(ov_cyc - acc_cyc), 128'd5);
    step();
    check_eq("exp_q_drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
